vram_write_arbiter: RTL
=======================

Name: vram_write_arbiter

Overview:
- Owns the single write port of the 32x32, 3-bit video memory.
- Arbitrates between two requesters:
  - CPU single-cycle pixel writes (WVM path), which have strict priority.
  - A built-in rectangle-fill engine, which rasters a rectangle with a constant colour using the remaining write slots.
- Sits between the CPU execute stage and the video RAM write port; the VGA read side is unaffected.

Parameters:
- COLOR_WIDTH, 3, pixel colour width ({R,G,B}).
- COORD_WIDTH, 5, bits per X/Y cell coordinate; memory address width = 2*COORD_WIDTH.

Ports:
- Clock  in  1  system clock; all state on rising edge.
- Reset  in  1  asynchronous, active-low reset (0 = reset).
- iCpuWrite  in  1  CPU write request, single-cycle, never stalled.
- iCpuAddr  in  2*COORD_WIDTH  CPU write address {row,col}.
- iCpuColor  in  COLOR_WIDTH  CPU write colour.
- iFillStart  in  1  start a rectangle fill; honoured only in IDLE.
- iFillX0, iFillY0, iFillX1, iFillY1  in  COORD_WIDTH each  rectangle corners, inclusive, any order.
- iFillColor  in  COLOR_WIDTH  fill colour.
- iAbort  in  1  cancel an in-progress fill.
- oMemWrite  out  1  video RAM write enable.
- oMemAddr  out  2*COORD_WIDTH  video RAM write address {Y,X}.
- oMemData  out  COLOR_WIDTH  video RAM write data.
- oBusy  out  1  high while state != IDLE.
- oDone  out  1  one-cycle pulse when a fill completes normally.
- oFillCount  out  2*COORD_WIDTH+1  number of fill cells written by the current/last fill.

Behaviour:

Reset:
- Reset=0 asynchronously forces state=IDLE and clears oMemWrite, oMemAddr, oMemData, oDone, oFillCount and the cursor.
- oBusy=0 during reset.

Output timing:
- oMemWrite, oMemAddr and oMemData are registered; latency is 1 cycle from request to port.

CPU path:
- iCpuWrite=1 at edge t drives oMemWrite=1, oMemAddr=iCpuAddr, oMemData=iCpuColor after edge t.
- This holds in every state.
- CPU writes are never dropped or delayed.

States:
- IDLE
  - iFillStart=1 latches xmin=min(X0,X1), xmax=max, ymin, ymax and the colour.
  - Cursor is set to (xmin,ymin), oFillCount is set to 0, next state = FILL.
  - Without iFillStart, the port is idle unless a CPU write occurs.
- FILL
  - Each edge with iCpuWrite=0:
    - Issue a fill write: oMemAddr={cy,cx}, oMemData=fill colour, oFillCount++.
    - Advance the cursor in raster order: cx++; if cx==xmax then cx=xmin and cy++.
  - If the issued cell is (xmax,ymax), next state = DONE.
  - Each edge with iCpuWrite=1: the CPU write is issued and the cursor and count hold. No cell is skipped or duplicated.
  - iAbort=1 (and iCpuWrite=0) at an edge:
    - No fill write is issued; next state = IDLE.
    - oDone is not pulsed; oFillCount holds the cells already written.
  - iAbort=1 together with iCpuWrite=1: the CPU write is issued and the abort still takes effect.
  - iFillStart is ignored.
- DONE
  - oDone=1 for exactly one cycle; next edge goes to IDLE.
  - A CPU write is serviced normally.
  - iFillStart is ignored.

Rules:
- A fill of w*h cells with no CPU contention takes exactly w*h write cycles after entering FILL.
- The degenerate 1x1 rectangle writes one cell, then DONE.
- A full-screen fill gives oFillCount=1024, which needs 11 bits.
- Coordinates never wrap: the cursor is bounded by the latched min/max.
- Changes to iFill* inputs after start have no effect.
- oBusy is combinational from state.
- oFillCount holds its value until the next accepted iFillStart.

Test Plan:
- CPU write in IDLE: iCpuWrite=1, iCpuAddr=10'h3FF, iCpuColor=5 -> next cycle oMemWrite=1, oMemAddr=3FF, oMemData=5; following cycle oMemWrite=0.
- 2x2 fill: corners (1,1)-(2,2), colour 3.
  - Expect writes to 0x021, 0x022, 0x041, 0x042 on 4 consecutive cycles.
  - Then oDone pulses once, oFillCount=4, oBusy drops.
- Swapped corners: X0=2, X1=1, Y0=2, Y1=1 -> identical write sequence and count as the 2x2 fill.
- Contention: CPU write (addr 0x155, colour 7) on the 2nd fill cycle of the 2x2 fill.
  - Port sequence: 0x021, 0x155(7), 0x022, 0x041, 0x042.
  - Total 5 write cycles; oFillCount=4.
- Full screen and abort:
  - (0,0)-(31,31) -> 1024 fill writes; last address 0x3FF; oFillCount=1024; one oDone.
  - Repeat with iAbort after 10 writes -> oBusy=0 next cycle, no oDone, oFillCount=10.
- Reset: Reset=0 asserted mid-fill between edges -> oMemWrite=0, oBusy=0, oFillCount=0 immediately, with no clock edge required.

Source files
------------

// File: rtl/vram_write_arbiter.sv
// Write-port arbiter for the 32x32 video RAM. CPU pixel writes always win.
// The rectangle-fill engine uses the cycles that the CPU leaves free.
module vram_write_arbiter #(
    parameter int COLOR_WIDTH = 3,
    parameter int COORD_WIDTH = 5
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       iCpuWrite,
    input  logic [2*COORD_WIDTH-1:0]   iCpuAddr,
    input  logic [COLOR_WIDTH-1:0]     iCpuColor,
    input  logic                       iFillStart,
    input  logic [COORD_WIDTH-1:0]     iFillX0,
    input  logic [COORD_WIDTH-1:0]     iFillY0,
    input  logic [COORD_WIDTH-1:0]     iFillX1,
    input  logic [COORD_WIDTH-1:0]     iFillY1,
    input  logic [COLOR_WIDTH-1:0]     iFillColor,
    input  logic                       iAbort,
    output logic                       oMemWrite,
    output logic [2*COORD_WIDTH-1:0]   oMemAddr,
    output logic [COLOR_WIDTH-1:0]     oMemData,
    output logic                       oBusy,
    output logic                       oDone,
    output logic [2*COORD_WIDTH:0]     oFillCount
);

    localparam int AW = 2 * COORD_WIDTH;
    localparam int CW = 2 * COORD_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  stateReg, stateNext;
    logic [COORD_WIDTH-1:0]  xMinReg, xMinNext, xMaxReg, xMaxNext;
    logic [COORD_WIDTH-1:0]  yMinReg, yMinNext, yMaxReg, yMaxNext;
    logic [COORD_WIDTH-1:0]  cxReg, cxNext, cyReg, cyNext;
    logic [COLOR_WIDTH-1:0]  colorReg, colorNext;
    logic [CW-1:0]           countReg, countNext;
    logic                    memWriteReg, memWriteNext;
    logic [AW-1:0]           memAddrReg, memAddrNext;
    logic [COLOR_WIDTH-1:0]  memDataReg, memDataNext;

    logic                    rowEnd;
    logic                    lastCell;

    assign rowEnd   = (cxReg == xMaxReg);
    assign lastCell = rowEnd && (cyReg == yMaxReg);

    always_comb begin
        stateNext    = stateReg;
        xMinNext     = xMinReg;
        xMaxNext     = xMaxReg;
        yMinNext     = yMinReg;
        yMaxNext     = yMaxReg;
        cxNext       = cxReg;
        cyNext       = cyReg;
        colorNext    = colorReg;
        countNext    = countReg;
        memWriteNext = 1'b0;
        memAddrNext  = memAddrReg;
        memDataNext  = memDataReg;

        case (stateReg)
            IDLE: begin
                if (iFillStart) begin
                    xMinNext  = (iFillX0 < iFillX1) ? iFillX0 : iFillX1;
                    xMaxNext  = (iFillX0 < iFillX1) ? iFillX1 : iFillX0;
                    yMinNext  = (iFillY0 < iFillY1) ? iFillY0 : iFillY1;
                    yMaxNext  = (iFillY0 < iFillY1) ? iFillY1 : iFillY0;
                    cxNext    = (iFillX0 < iFillX1) ? iFillX0 : iFillX1;
                    cyNext    = (iFillY0 < iFillY1) ? iFillY0 : iFillY1;
                    colorNext = iFillColor;
                    countNext = '0;
                    stateNext = FILL;
                end
            end
            FILL: begin
                if (iAbort) begin
                    stateNext = IDLE;
                end else if (!iCpuWrite) begin
                    // Only a free slot consumes a cell; a CPU cycle leaves cursor and count untouched.
                    memWriteNext = 1'b1;
                    memAddrNext  = {cyReg, cxReg};
                    memDataNext  = colorReg;
                    countNext    = countReg + CW'(1);
                    if (rowEnd) begin
                        cxNext = xMinReg;
                        if (!lastCell) begin
                            cyNext = cyReg + COORD_WIDTH'(1);
                        end
                    end else begin
                        cxNext = cxReg + COORD_WIDTH'(1);
                    end
                    if (lastCell) begin
                        stateNext = DONE;
                    end
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        // CPU writes override whatever the fill engine wanted this cycle.
        if (iCpuWrite) begin
            memWriteNext = 1'b1;
            memAddrNext  = iCpuAddr;
            memDataNext  = iCpuColor;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            stateReg    <= IDLE;
            xMinReg     <= '0;
            xMaxReg     <= '0;
            yMinReg     <= '0;
            yMaxReg     <= '0;
            cxReg       <= '0;
            cyReg       <= '0;
            colorReg    <= '0;
            countReg    <= '0;
            memWriteReg <= 1'b0;
            memAddrReg  <= '0;
            memDataReg  <= '0;
        end else begin
            stateReg    <= stateNext;
            xMinReg     <= xMinNext;
            xMaxReg     <= xMaxNext;
            yMinReg     <= yMinNext;
            yMaxReg     <= yMaxNext;
            cxReg       <= cxNext;
            cyReg       <= cyNext;
            colorReg    <= colorNext;
            countReg    <= countNext;
            memWriteReg <= memWriteNext;
            memAddrReg  <= memAddrNext;
            memDataReg  <= memDataNext;
        end
    end

    assign oMemWrite  = memWriteReg;
    assign oMemAddr   = memAddrReg;
    assign oMemData   = memDataReg;
    assign oBusy      = (stateReg != IDLE);
    assign oDone      = (stateReg == DONE);
    assign oFillCount = countReg;

endmodule
